// File: rtl/id_ex_stage_if.sv
// ID->EX stage bus: ID-side decode bundle in, registered EX-side bundle and stall out.
// bubble_cnt exists only when ID_EX_BUBBLE_COUNT_EN is defined.
interface id_ex_stage_if;
    localparam int unsigned CTRL_W = 17;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 16;

    logic              en;
    logic              flush;
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic [WORD_W-1:0] id_rdat1;
    logic [WORD_W-1:0] id_rdat2;
    logic [IMM_W-1:0]  id_imm;
    logic [WORD_W-1:0] id_npc;

    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_wsel;
    logic [WORD_W-1:0] ex_rdat1;
    logic [WORD_W-1:0] ex_rdat2;
    logic [IMM_W-1:0]  ex_imm;
    logic [WORD_W-1:0] ex_npc;
    logic              stall;
    logic              ex_halt;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [WORD_W-1:0] bubble_cnt;

    modport master (
        output en, flush, id_ctrl, id_rs, id_rt, id_rd, id_rdat1, id_rdat2, id_imm, id_npc,
        input  ex_ctrl, ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_npc,
               stall, ex_halt, bubble_cnt
    );
    modport slave (
        input  en, flush, id_ctrl, id_rs, id_rt, id_rd, id_rdat1, id_rdat2, id_imm, id_npc,
        output ex_ctrl, ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_npc,
               stall, ex_halt, bubble_cnt
    );
`else
    modport master (
        output en, flush, id_ctrl, id_rs, id_rt, id_rd, id_rdat1, id_rdat2, id_imm, id_npc,
        input  ex_ctrl, ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_npc,
               stall, ex_halt
    );
    modport slave (
        input  en, flush, id_ctrl, id_rs, id_rt, id_rd, id_rdat1, id_rdat2, id_imm, id_npc,
        output ex_ctrl, ex_rs, ex_rt, ex_wsel, ex_rdat1, ex_rdat2, ex_imm, ex_npc,
               stall, ex_halt
    );
`endif
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use stall, flush bubbles and sticky halt.
// Optional hazard-bubble counter enabled by defining ID_EX_BUBBLE_COUNT_EN.
module id_ex_stage (
    input logic          CLK,
    input logic          nRST,
    id_ex_stage_if.slave bus
);
    localparam int unsigned CTRL_W = 17;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 16;

    typedef struct packed {
        logic       WrLinkReg;
        logic       ShiftUp;
        logic       MemRd;
        logic       ExtOp;
        logic [1:0] PCSrc;
        logic       ALUSrc;
        logic       MemToReg;
        logic       MemWr;
        logic       RegWr;
        logic       RegDst;
        logic       halt;
        logic [3:0] ALUOp;
        logic       Atomic;
    } ctrl_t;

    ctrl_t             idCtrl;
    ctrl_t             exCtrl;
    logic [REG_W-1:0]  exRs;
    logic [REG_W-1:0]  exRt;
    logic [REG_W-1:0]  exWsel;
    logic [REG_W-1:0]  wsel;
    logic [WORD_W-1:0] exRdat1;
    logic [WORD_W-1:0] exRdat2;
    logic [WORD_W-1:0] exNpc;
    logic [IMM_W-1:0]  exImm;
    logic              exHalt;
    logic              hz;
    logic              loadBubble;

    assign idCtrl = ctrl_t'(bus.id_ctrl);

    // Link register wins over rd, rd wins over rt
    always_comb begin
        wsel = bus.id_rt;
        if (idCtrl.WrLinkReg) begin
            wsel = REG_W'(31);
        end else if (idCtrl.RegDst) begin
            wsel = bus.id_rd;
        end
    end

    // Load-use hazard; a flushed ID instruction never needs to stall
    always_comb begin
        hz = exCtrl.MemRd && (exWsel != '0) &&
             ((exWsel == bus.id_rs) || (exWsel == bus.id_rt));
        loadBubble = exHalt || bus.flush || hz;
    end

    assign bus.stall = hz && !bus.flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exCtrl  <= '0;
            exRs    <= '0;
            exRt    <= '0;
            exWsel  <= '0;
            exRdat1 <= '0;
            exRdat2 <= '0;
            exImm   <= '0;
            exNpc   <= '0;
            exHalt  <= 1'b0;
        end else if (bus.en) begin
            if (loadBubble) begin
                exCtrl  <= '0;
                exRs    <= '0;
                exRt    <= '0;
                exWsel  <= '0;
                exRdat1 <= '0;
                exRdat2 <= '0;
                exImm   <= '0;
                exNpc   <= '0;
            end else begin
                exCtrl  <= idCtrl;
                exRs    <= bus.id_rs;
                exRt    <= bus.id_rt;
                exWsel  <= wsel;
                exRdat1 <= bus.id_rdat1;
                exRdat2 <= bus.id_rdat2;
                exImm   <= bus.id_imm;
                exNpc   <= bus.id_npc;
                if (idCtrl.halt) begin
                    exHalt <= 1'b1;
                end
            end
        end
    end

    assign bus.ex_ctrl  = CTRL_W'(exCtrl);
    assign bus.ex_rs    = exRs;
    assign bus.ex_rt    = exRt;
    assign bus.ex_wsel  = exWsel;
    assign bus.ex_rdat1 = exRdat1;
    assign bus.ex_rdat2 = exRdat2;
    assign bus.ex_imm   = exImm;
    assign bus.ex_npc   = exNpc;
    assign bus.ex_halt  = exHalt;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [WORD_W-1:0] bubbleCnt;

    // Counts only hazard bubbles; halt and flush take priority over hz
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bubbleCnt <= '0;
        end else if (bus.en && !exHalt && !bus.flush && hz && (bubbleCnt != '1)) begin
            bubbleCnt <= bubbleCnt + WORD_W'(1);
        end
    end

    assign bus.bubble_cnt = bubbleCnt;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus reset/stall corner sequences.
module tb_id_ex_stage;
    localparam logic [16:0] ADD  = 17'h000C0;  // RegWr|RegDst
    localparam logic [16:0] LW   = 17'h04680;  // MemRd|ALUSrc|MemToReg|RegWr
    localparam logic [16:0] JAL  = 17'h100C0;  // WrLinkReg|RegDst|RegWr
    localparam logic [16:0] HALT = 17'h00020;
    localparam int NV = 23;

    typedef struct {
        logic        en;
        logic        flush;
        logic [16:0] ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1;
        logic        expStall;
        logic [16:0] expCtrl;
        logic [4:0]  expRs, expRt, expWsel;
        logic [31:0] expD1;
        logic        expHalt;
        logic [31:0] expCnt;
    } vec_t;

    logic clk;
    logic nRST;
    int   nCmp;
    int   nFail;
    vec_t vecs[NV];

    id_ex_stage_if bus();

    id_ex_stage dut (
        .CLK (clk),
        .nRST(nRST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] d2Of(input logic [31:0] x);
        return {x[15:0], x[31:16]};
    endfunction
    function automatic logic [15:0] immOf(input logic [31:0] x);
        return x[31:16];
    endfunction
    function automatic logic [31:0] npcOf(input logic [31:0] x);
        return x << 1;
    endfunction

    function automatic vec_t mk(input logic en, input logic flush, input logic [16:0] ctrl,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] d1, input logic expStall,
                                input logic [16:0] expCtrl, input logic [4:0] expRs,
                                input logic [4:0] expRt, input logic [4:0] expWsel,
                                input logic [31:0] expD1, input logic expHalt,
                                input logic [31:0] expCnt);
        vec_t v;
        v.en = en; v.flush = flush; v.ctrl = ctrl; v.rs = rs; v.rt = rt; v.rd = rd; v.d1 = d1;
        v.expStall = expStall; v.expCtrl = expCtrl; v.expRs = expRs; v.expRt = expRt;
        v.expWsel = expWsel; v.expD1 = expD1; v.expHalt = expHalt; v.expCnt = expCnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic flush, input logic [16:0] ctrl,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1);
        bus.en       = en;
        bus.flush    = flush;
        bus.id_ctrl  = ctrl;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.id_rd    = rd;
        bus.id_rdat1 = d1;
        bus.id_rdat2 = d2Of(d1);
        bus.id_imm   = immOf(d1);
        bus.id_npc   = npcOf(d1);
    endtask

    task automatic chkEx(input string tag, input logic [16:0] ctrl, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] wsel, input logic [31:0] d1,
                         input logic halt);
        chk({tag, " ex_ctrl"},  32'(bus.ex_ctrl), 32'(ctrl));
        chk({tag, " ex_rs"},    32'(bus.ex_rs), 32'(rs));
        chk({tag, " ex_rt"},    32'(bus.ex_rt), 32'(rt));
        chk({tag, " ex_wsel"},  32'(bus.ex_wsel), 32'(wsel));
        chk({tag, " ex_rdat1"}, bus.ex_rdat1, d1);
        chk({tag, " ex_rdat2"}, bus.ex_rdat2, d2Of(d1));
        chk({tag, " ex_imm"},   32'(bus.ex_imm), 32'(immOf(d1)));
        chk({tag, " ex_npc"},   bus.ex_npc, npcOf(d1));
        chk({tag, " ex_halt"},  32'(bus.ex_halt), 32'(halt));
    endtask

    initial begin
        nCmp  = 0;
        nFail = 0;
        //            en fl ctrl  rs  rt  rd  d1              st expCtrl rs rt wsel expD1          h cnt
        vecs[0]  = mk(1, 0, ADD,  1,  2,  3, 32'hA000_0001, 0, ADD,  1, 2,  3, 32'hA000_0001, 0, 0);
        vecs[1]  = mk(1, 0, LW,   1,  8,  0, 32'hA001_0002, 0, LW,   1, 8,  8, 32'hA001_0002, 0, 0);
        vecs[2]  = mk(1, 0, ADD,  8,  2,  4, 32'hA002_0003, 1, '0,   0, 0,  0, 32'h0,         0, 1);
        vecs[3]  = mk(1, 0, ADD,  8,  2,  4, 32'hA002_0003, 0, ADD,  8, 2,  4, 32'hA002_0003, 0, 1);
        vecs[4]  = mk(1, 0, LW,   2,  0,  0, 32'hA004_0005, 0, LW,   2, 0,  0, 32'hA004_0005, 0, 1);
        vecs[5]  = mk(1, 0, ADD,  0,  0,  5, 32'hA005_0006, 0, ADD,  0, 0,  5, 32'hA005_0006, 0, 1);
        vecs[6]  = mk(1, 0, LW,   3,  9,  0, 32'hA006_0007, 0, LW,   3, 9,  9, 32'hA006_0007, 0, 1);
        vecs[7]  = mk(1, 0, ADD,  4,  5,  6, 32'hA007_0008, 0, ADD,  4, 5,  6, 32'hA007_0008, 0, 1);
        vecs[8]  = mk(1, 0, LW,   1, 10,  0, 32'hA008_0009, 0, LW,   1, 10, 10, 32'hA008_0009, 0, 1);
        vecs[9]  = mk(1, 1, ADD,  1, 10, 11, 32'hA009_000A, 0, '0,   0, 0,  0, 32'h0,         0, 1);
        vecs[10] = mk(1, 0, ADD,  1,  2, 12, 32'hA00A_000B, 0, ADD,  1, 2, 12, 32'hA00A_000B, 0, 1);
        vecs[11] = mk(0, 0, ADD,  3,  4, 13, 32'hB00B_000C, 0, ADD,  1, 2, 12, 32'hA00A_000B, 0, 1);
        vecs[12] = mk(0, 0, LW,   5,  6, 14, 32'hB00C_000D, 0, ADD,  1, 2, 12, 32'hA00A_000B, 0, 1);
        vecs[13] = mk(0, 1, ADD,  7,  8, 15, 32'hB00D_000E, 0, ADD,  1, 2, 12, 32'hA00A_000B, 0, 1);
        vecs[14] = mk(1, 0, JAL,  0,  6,  7, 32'hA00E_000F, 0, JAL,  0, 6, 31, 32'hA00E_000F, 0, 1);
        vecs[15] = mk(1, 0, LW,   0,  8,  0, 32'hA00F_0010, 0, LW,   0, 8,  8, 32'hA00F_0010, 0, 1);
        vecs[16] = mk(0, 0, ADD,  8,  3, 17, 32'hA010_0011, 1, LW,   0, 8,  8, 32'hA00F_0010, 0, 1);
        vecs[17] = mk(1, 0, ADD,  8,  3, 17, 32'hA010_0011, 1, '0,   0, 0,  0, 32'h0,         0, 2);
        vecs[18] = mk(1, 0, ADD,  8,  3, 17, 32'hA010_0011, 0, ADD,  8, 3, 17, 32'hA010_0011, 0, 2);
        vecs[19] = mk(1, 0, HALT, 0,  0,  0, 32'hA012_0013, 0, HALT, 0, 0,  0, 32'hA012_0013, 1, 2);
        vecs[20] = mk(1, 0, ADD,  1,  2,  3, 32'hA013_0014, 0, '0,   0, 0,  0, 32'h0,         1, 2);
        vecs[21] = mk(1, 1, ADD,  1,  2,  3, 32'hA014_0015, 0, '0,   0, 0,  0, 32'h0,         1, 2);
        vecs[22] = mk(1, 0, LW,   1,  2,  0, 32'hA015_0016, 0, '0,   0, 0,  0, 32'h0,         1, 2);

        // Reset with random inputs
        nRST = 1'b0;
        drive(1'b1, 1'($urandom), 17'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom);
        repeat (2) @(posedge clk);
        #1;
        chkEx("reset", '0, 0, 0, 0, 32'h0, 1'b0);
        chk("reset stall", 32'(bus.stall), 32'h0);
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk("reset bubble_cnt", bus.bubble_cnt, 32'h0);
`endif
        @(negedge clk);
        nRST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].flush, vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                  vecs[i].d1);
            #1;
            chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vecs[i].expStall));
            @(posedge clk);
            #1;
            chkEx($sformatf("v%0d", i), vecs[i].expCtrl, vecs[i].expRs, vecs[i].expRt,
                  vecs[i].expWsel, vecs[i].expD1, vecs[i].expHalt);
`ifdef ID_EX_BUBBLE_COUNT_EN
            chk($sformatf("v%0d bubble_cnt", i), bus.bubble_cnt, vecs[i].expCnt);
`endif
        end

        // Async reset pulse mid-cycle clears sticky halt immediately
        @(negedge clk);
        #2;
        nRST = 1'b0;
        #1;
        chk("rst halt ex_halt", 32'(bus.ex_halt), 32'h0);
        chk("rst halt ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
        @(negedge clk);
        nRST = 1'b1;

        // Reset asserted while stalling on a load-use hazard
        drive(1'b1, 1'b0, LW, 5'd0, 5'd8, 5'd0, 32'hC000_0001);
        @(posedge clk);
        #1;
        chk("midstall lw wsel", 32'(bus.ex_wsel), 32'd8);
        @(negedge clk);
        drive(1'b1, 1'b0, ADD, 5'd8, 5'd1, 5'd20, 32'hC001_0002);
        #1;
        chk("midstall stall high", 32'(bus.stall), 32'h1);
        nRST = 1'b0;
        #1;
        chk("midstall stall cleared", 32'(bus.stall), 32'h0);
        chk("midstall ex_ctrl", 32'(bus.ex_ctrl), 32'h0);
        chk("midstall ex_wsel", 32'(bus.ex_wsel), 32'h0);
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk("midstall bubble_cnt", bus.bubble_cnt, 32'h0);
`endif
        @(negedge clk);
        nRST = 1'b1;
        #1;
        chk("post-reset stall", 32'(bus.stall), 32'h0);
        @(posedge clk);
        #1;
        chkEx("post-reset capture", ADD, 5'd8, 5'd1, 5'd20, 32'hC001_0002, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
